instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words in program memory (power of two).
REQ-002 SHALL have parameter AW, default 8, meaning word-address width, log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, meaning single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port prog_we, input, 1, meaning program-memory write strobe.
REQ-006 SHALL have port prog_addr, input, AW, meaning program write word address.
REQ-007 SHALL have port prog_data, input, 32, meaning program write data.
REQ-008 SHALL have port start, input, 1, meaning begin fetching at word 0.
REQ-009 SHALL have port instruction, output, 32, meaning fetched instruction word.
REQ-010 SHALL have port pc_out, output, 32, meaning zero-extended word address of instruction.
REQ-011 SHALL have port instr_valid, output, 1, meaning instruction/pc_out hold a valid word.
REQ-012 SHALL have port instr_ready, input, 1, meaning consumer accepts the word this cycle.
REQ-013 SHALL have port redirect_valid, input, 1, meaning consumed word is a taken branch or jump.
REQ-014 SHALL have port redirect_jump, input, 1, meaning 1 = jump, 0 = branch.
REQ-015 SHALL have port redirect_offset, input, 32, meaning signed word offset for branches.
REQ-016 SHALL have port redirect_target, input, 26, meaning jump word address.
REQ-017 SHALL have port halted, output, 1, meaning FSM is in HALT.
REQ-018 SHALL have port fault, output, 1, meaning FSM is in FAULT (only with the macro; otherwise tied 0).

Function
REQ-019 SHALL implement FSM states IDLE, RUN, HALT, FAULT.
REQ-020 SHALL accept prog_we only in IDLE or HALT, writing mem[prog_addr] <= prog_data; ignored in RUN/FAULT.
REQ-021 SHALL go IDLE/HALT -> RUN on start, setting internal pc to 0 and clearing instr_valid.
REQ-022 SHALL, in RUN, load instruction <= mem[pc], pc_out <= pc, instr_valid <= 1, pc <= pc+1 whenever instr_valid is 0 or (instr_valid and instr_ready).
REQ-023 SHALL hold instruction, pc_out, instr_valid stable while instr_valid=1 and instr_ready=0.
REQ-024 SHALL give latency of one cycle: start at edge N -> instr_valid=1 with mem[0] after edge N+1.
REQ-025 SHALL sample redirect_* only when instr_valid and instr_ready are both 1; otherwise ignore them.
REQ-026 SHALL compute branch target pc_out+1+redirect_offset and jump target redirect_target, truncated to AW bits.
REQ-027 SHALL, on redirect, clear instr_valid and set pc to the target, giving exactly one bubble cycle; the word at target appears the following cycle.
REQ-028 SHALL treat 32'hFFFFFFFF as halt word: when consumed, go RUN -> HALT, clear instr_valid, fetch nothing further; no prefetch occurs beyond a presented halt word.
REQ-029 SHALL give redirect priority over halt detection if both apply to the same consumed word (halt word is never a branch; redirect wins).
REQ-030 SHALL wrap pc modulo DEPTH on increment when the macro is absent.
REQ-031 SHALL ignore start while in RUN or FAULT.

Reset
REQ-032 SHALL, on rst_n low, asynchronously force IDLE, pc=0, instruction=0, pc_out=0, instr_valid=0, halted=0, fault=0.
REQ-033 SHALL not reset program memory contents; reset mid-RUN discards the in-flight word.

Configuration
REQ-034 SHALL, when IFETCH_BOUNDS_CHECK_EN is defined, enter FAULT (fault=1, instr_valid=0) instead of fetching when pc would exceed DEPTH-1 or a redirect target has nonzero bits above AW-1 (branch target before truncation outside 0..DEPTH-1); FAULT exits only by reset.
REQ-035 SHALL, when IFETCH_BOUNDS_CHECK_EN is undefined, omit FAULT, tie fault to 0, and truncate/wrap all addresses.

Verification
REQ-036 SHALL cover: load mem[0..3]=A,B,C,FFFFFFFF, start, instr_ready=1 -> A,B,C,FFFFFFFF on pc_out 0..3 consecutive cycles, then halted=1.
REQ-037 SHALL cover: instr_ready=0 for 3 cycles with B presented -> instruction=B, pc_out=1 held, pc not advanced.
REQ-038 SHALL cover: branch at pc_out=2, offset=+3 -> one bubble, then pc_out=6.
REQ-039 SHALL cover: jump target=0x10 at pc_out=5 -> one bubble, then pc_out=0x10 with mem[0x10].
REQ-040 SHALL cover: DEPTH=256, run to pc 255 with no halt -> without macro next pc_out=0; with macro fault=1, instr_valid=0.
REQ-041 SHALL cover: rst_n low mid-RUN -> outputs zero immediately, IDLE; start -> mem[0] refetched, memory intact.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: writable program memory, IDLE/RUN/HALT fetch FSM with a valid/ready
// output stage and branch/jump redirect. Define IFETCH_BOUNDS_CHECK_EN to enable the FAULT state.
module instruction_fetch #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          start,
  output logic [31:0]   instruction,
  output logic [31:0]   pc_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect_valid,
  input  logic          redirect_jump,
  input  logic [31:0]   redirect_offset,
  input  logic [25:0]   redirect_target,
  output logic          halted,
  output logic          fault
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  RUN       = 2'd1;
  localparam logic [1:0]  HALT      = 2'd2;
  localparam logic [1:0]  FAULT     = 2'd3;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // With bounds checking the pc carries one extra bit so stepping past the last word is visible.
`ifdef IFETCH_BOUNDS_CHECK_EN
  localparam int PCW = AW + 1;
`else
  localparam int PCW = AW;
`endif

  logic [1:0]     state;
  logic [PCW-1:0] pc;
  logic [AW-1:0]  pc_q;
  logic [31:0]    mem [DEPTH];

  logic           consume;
  logic [31:0]    branch_full;
  logic [31:0]    jump_full;
  logic [31:0]    target_full;
  logic [AW-1:0]  target;
  logic           pc_oob;
  logic           target_oob;

  assign consume     = instr_valid && instr_ready;
  assign branch_full = {{(32-AW){1'b0}}, pc_q} + 32'd1 + redirect_offset;
  assign jump_full   = {6'd0, redirect_target};
  assign target_full = redirect_jump ? jump_full : branch_full;
  assign target      = target_full[AW-1:0];

  assign pc_out = {{(32-AW){1'b0}}, pc_q};
  assign halted = (state == HALT);

`ifdef IFETCH_BOUNDS_CHECK_EN
  assign pc_oob     = pc[AW];
  assign target_oob = |target_full[31:AW];
  assign fault      = (state == FAULT);
`else
  logic unused_target_bits;
  assign unused_target_bits = ^target_full[31:AW];
  assign pc_oob     = 1'b0;
  assign target_oob = 1'b0;
  assign fault      = 1'b0;
`endif

  // Program memory is deliberately outside reset so a restart refetches the loaded program.
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE || state == HALT)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      pc_q        <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= RUN;
            pc          <= '0;
            instr_valid <= 1'b0;
          end
        end
        RUN: begin
          // Redirect beats halt detection; both leave a single bubble before the next word.
          if (consume && redirect_valid) begin
            instr_valid <= 1'b0;
            if (target_oob) state <= FAULT;
            else            pc    <= PCW'(target);
          end else if (consume && instruction == HALT_WORD) begin
            state       <= HALT;
            instr_valid <= 1'b0;
          end else if (!instr_valid || instr_ready) begin
            if (pc_oob) begin
              state       <= FAULT;
              instr_valid <= 1'b0;
            end else begin
              instruction <= mem[pc[AW-1:0]];
              pc_q        <= pc[AW-1:0];
              instr_valid <= 1'b1;
              pc          <= pc + PCW'(1);
            end
          end
        end
        FAULT: begin
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a driver issues random handshakes/redirects and queues
// the expected word stream from an address-level model; a negedge monitor checks what the DUT presents.
module tb_instruction_fetch;

  localparam int          DEPTH     = 256;
  localparam int          AW        = 8;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] WORD_A    = 32'h1111_AAAA;
  localparam logic [31:0] WORD_B    = 32'h2222_BBBB;
  localparam logic [31:0] WORD_C    = 32'h3333_CCCC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic          start = 1'b0;
  logic [31:0]   instruction;
  logic [31:0]   pc_out;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic          redirect_jump = 1'b0;
  logic [31:0]   redirect_offset = '0;
  logic [25:0]   redirect_target = '0;
  logic          halted;
  logic          fault;

  typedef struct {
    int          pc;
    logic [31:0] data;
    int          gap;
  } exp_t;

  typedef struct {
    int pc;
    bit jump;
    int off;
    int tgt;
  } dir_t;

  exp_t        scb[$];
  dir_t        dir_q[$];
  logic [31:0] mem_m [DEPTH];

  int n_checks = 0;
  int n_fail = 0;
  int ready_pct = 100;
  int redir_pct = 0;
  int stall_pc = -1;
  int stall_left = 0;
  int cur = 0;
  int gap = 0;
  bit first = 1'b1;
  bit want_halt = 1'b0;

  instruction_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .prog_we         (prog_we),
    .prog_addr       (prog_addr),
    .prog_data       (prog_data),
    .start           (start),
    .instruction     (instruction),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_jump   (redirect_jump),
    .redirect_offset (redirect_offset),
    .redirect_target (redirect_target),
    .halted          (halted),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT_WORD) w = 32'h0;
    return w;
  endfunction

  function automatic dir_t random_redirect(input int from);
    dir_t d;
    d.pc   = from;
    d.jump = 1'($urandom_range(1));
`ifdef IFETCH_BOUNDS_CHECK_EN
    d.tgt = int'($urandom_range(DEPTH - 1));
    d.off = d.tgt - (from + 1);
`else
    d.tgt = int'($urandom_range(32'h03FF_FFFF));
    d.off = int'($urandom_range(1000)) - 500;
`endif
    return d;
  endfunction

  // Monitor: compares every presented word against the queue head and pops on handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      gap       = 0;
      first     = 1'b1;
      want_halt = 1'b0;
    end else begin
      if (want_halt) begin
        check_output("halt_entry", {30'd0, halted, instr_valid}, 32'd2);
        want_halt = 1'b0;
      end
      if (start) begin
        gap = 0;
      end else if (instr_valid) begin
        if (scb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_word: actual pc_out %0d, required no word", pc_out);
        end else begin
          e = scb[0];
          check_output("pc_out", pc_out, e.pc);
          check_output("instruction", instruction, e.data);
          if (first) check_output("bubble_gap", gap, e.gap);
          first = 1'b0;
          if (instr_ready) begin
            void'(scb.pop_front());
            first = 1'b1;
            gap   = 0;
            if (e.data == HALT_WORD && !redirect_valid) want_halt = 1'b1;
          end
        end
      end else begin
        gap++;
      end
    end
  end

  task automatic load_word(input int addr, input logic [31:0] data);
    prog_we     = 1'b1;
    prog_addr   = AW'(addr);
    prog_data   = data;
    mem_m[addr] = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_output("rst_instruction", instruction, 32'd0);
    check_output("rst_pc_out", pc_out, 32'd0);
    check_output("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_output("rst_halted", {31'd0, halted}, 32'd0);
    check_output("rst_fault", {31'd0, fault}, 32'd0);
    scb.delete();
    dir_q.delete();
    stall_left = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Driver: status 0 = cycle budget spent, 1 = halt word consumed, 2 = fault expected.
  task automatic apply_stimulus(input int max_cycles, output int status);
    bit   rdy;
    bit   redir;
    int   nxt;
    int   gp;
    dir_t d;
    status = 0;
    start  = 1'b1;
    scb.push_back(exp_t'{0, mem_m[0], 1});
    cur = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < max_cycles && status == 0; c++) begin
      if (instr_valid && stall_left > 0 && cur == stall_pc) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = (int'($urandom_range(99)) < ready_pct);
      end
      instr_ready     = rdy;
      redirect_valid  = 1'($urandom_range(1));
      redirect_jump   = 1'($urandom_range(1));
      redirect_offset = $urandom;
      redirect_target = 26'($urandom);
      prog_we         = instr_valid && ($urandom_range(3) == 0);
      prog_addr       = AW'($urandom);
      prog_data       = $urandom;
      if (instr_valid && rdy) begin
        redirect_valid = 1'b0;
        if (mem_m[cur] == HALT_WORD) begin
          status = 1;
        end else begin
          redir = 1'b0;
          if (dir_q.size() > 0 && dir_q[0].pc == cur) begin
            d     = dir_q.pop_front();
            redir = 1'b1;
          end else if (int'($urandom_range(99)) < redir_pct) begin
            d     = random_redirect(cur);
            redir = 1'b1;
          end
          if (redir) begin
            redirect_valid  = 1'b1;
            redirect_jump   = d.jump;
            redirect_offset = d.off;
            redirect_target = 26'(d.tgt);
            nxt = d.jump ? (d.tgt % DEPTH) : (((cur + 1 + d.off) % DEPTH) + DEPTH) % DEPTH;
            gp  = 1;
          end else begin
            nxt = (cur + 1) % DEPTH;
            gp  = 0;
`ifdef IFETCH_BOUNDS_CHECK_EN
            if (cur == DEPTH - 1) status = 2;
`endif
          end
          if (status == 0) begin
            scb.push_back(exp_t'{nxt, mem_m[nxt], gp});
            cur = nxt;
          end
        end
      end
      @(posedge clk); #1;
    end
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    prog_we        = 1'b0;
  endtask

  task automatic expect_halted();
    idle_cycles(2);
    check_output("halted", {31'd0, halted}, 32'd1);
    check_output("fault_clear", {31'd0, fault}, 32'd0);
    check_output("scb_drained", scb.size(), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int st;
    @(posedge clk); #1;
    do_reset();

    for (int a = 0; a < DEPTH; a++) load_word(a, rand_word());
    load_word(0, WORD_A);
    load_word(1, WORD_B);
    load_word(2, WORD_C);
    load_word(3, HALT_WORD);
    load_word(8, HALT_WORD);
    load_word(18, HALT_WORD);

    $display("[TB] straight-line run to halt");
    apply_stimulus(20, st);
    expect_halted();

    $display("[TB] consumer stall on second word");
    stall_pc   = 1;
    stall_left = 3;
    apply_stimulus(20, st);
    expect_halted();

    $display("[TB] branch +3 at pc 2");
    dir_q.push_back(dir_t'{2, 1'b0, 3, 0});
    apply_stimulus(30, st);
    expect_halted();

    $display("[TB] branch to 5 then jump to 0x10");
    dir_q.push_back(dir_t'{2, 1'b0, 2, 0});
    dir_q.push_back(dir_t'{5, 1'b1, 0, 16});
    apply_stimulus(30, st);
    expect_halted();

    $display("[TB] run across the top of memory");
    dir_q.push_back(dir_t'{2, 1'b1, 0, 250});
    apply_stimulus(40, st);
`ifdef IFETCH_BOUNDS_CHECK_EN
    idle_cycles(2);
    check_output("oob_fault", {30'd0, fault, instr_valid}, 32'd2);
    do_reset();
`else
    expect_halted();
`endif

    $display("[TB] reset mid-run then restart");
    dir_q.push_back(dir_t'{1, 1'b1, 0, 250});
    apply_stimulus(5, st);
    do_reset();
    apply_stimulus(20, st);
    expect_halted();

    $display("[TB] randomized episodes");
    ready_pct = 70;
    redir_pct = 25;
    for (int ep = 0; ep < 8; ep++) begin
      for (int a = 0; a < DEPTH; a++) load_word(a, rand_word());
      for (int h = 0; h < 3; h++) load_word(int'($urandom_range(DEPTH - 1)), HALT_WORD);
      apply_stimulus(300, st);
      if (st == 1) begin
        expect_halted();
      end else begin
        idle_cycles(1);
        if (st == 2) check_output("rand_fault", {30'd0, fault, instr_valid}, 32'd2);
        do_reset();
      end
    end

    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
